// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word array with RISC-V byte/half/word lanes,
// fixed access latency reported on DStall, misaligned requests flagged on MemErr.
module dmem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  LS_op,
  output logic [31:0] MemData,
  output logic        DStall,
  output logic        MemErr
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam bit LAT1  = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       op_q, op_d;
  logic             store_q, store_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             req, misaligned, accept, finish;
  logic [AW-1:0]    eff_addr;
  logic [31:0]      eff_wdata;
  logic [2:0]       eff_op;
  logic             eff_store;
  logic [31:0]      rd_word, load_val, wr_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [3:0]       we_lanes;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^MemAddr[31:AW];
  assign req = MemRead | MemWrite;

  always_comb begin
    misaligned = 1'b0;
    case (LS_op)
      3'b001:  misaligned = MemAddr[0];
      3'b101:  misaligned = MemAddr[0] & ~MemWrite;
      3'b010:  misaligned = |MemAddr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) & req & ~misaligned;
  assign DStall = rst & (accept | (state_q == S_WAIT));
  assign MemErr = rst & (state_q == S_IDLE) & req & misaligned;

  // With a one-cycle latency the access completes on the accept edge, so the
  // live inputs stand in for the not-yet-latched request.
  assign eff_addr  = (state_q == S_IDLE) ? MemAddr[AW-1:0] : addr_q;
  assign eff_wdata = (state_q == S_IDLE) ? MemWriteData : wdata_q;
  assign eff_op    = (state_q == S_IDLE) ? LS_op : op_q;
  assign eff_store = (state_q == S_IDLE) ? MemWrite : store_q;
  assign finish    = rst & ((accept & LAT1) |
                     ((state_q == S_WAIT) & (cnt_q == CNT_W'(1))));

  assign rd_word = mem_q[eff_addr[AW-1:2]];
  assign rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (eff_addr[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    case (eff_op)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    we_lanes = 4'b0000;
    wr_word  = eff_wdata;
    case (eff_op[1:0])
      2'b00: begin
        we_lanes = 4'b0001 << eff_addr[1:0];
        wr_word  = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        we_lanes = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{eff_wdata[15:0]}};
      end
      default: we_lanes = 4'b1111;
    endcase
    if (!(finish && eff_store)) we_lanes = 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    store_d    = store_q;
    mem_data_d = mem_data_q;
    if (finish && !eff_store) mem_data_d = load_val;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = MemAddr[AW-1:0];
        wdata_d = MemWriteData;
        op_d    = LS_op;
        store_d = MemWrite;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = LAT1 ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      store_q    <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      store_q    <= store_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_lanes[i]) mem_q[eff_addr[AW-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

  assign MemData = mem_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 4) checked every cycle
// against an age-based behavioural model, plus directed literal expectations.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [2:0]  op    [3];
  logic [31:0] mdata [3];
  logic        stall [3];
  logic        err   [3];

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_n[0]), .MemAddr(addr[0]), .MemWriteData(wdata[0]),
    .MemRead(rd[0]), .MemWrite(wr[0]), .LS_op(op[0]),
    .MemData(mdata[0]), .DStall(stall[0]), .MemErr(err[0]));
  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst_n[1]), .MemAddr(addr[1]), .MemWriteData(wdata[1]),
    .MemRead(rd[1]), .MemWrite(wr[1]), .LS_op(op[1]),
    .MemData(mdata[1]), .DStall(stall[1]), .MemErr(err[1]));
  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst_n[2]), .MemAddr(addr[2]), .MemWriteData(wdata[2]),
    .MemRead(rd[2]), .MemWrite(wr[2]), .LS_op(op[2]),
    .MemData(mdata[2]), .DStall(stall[2]), .MemErr(err[2]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc++;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic bit aligned_fn(input logic r, input logic w, input logic [2:0] o, input logic [31:0] a);
    if (w) return !((o == 3'b001 && a[0]) || (o == 3'b010 && a[1:0] != 2'b00));
    return !(((o == 3'b001 || o == 3'b101) && a[0]) || (o == 3'b010 && a[1:0] != 2'b00));
  endfunction

  // Behavioural model: age counts cycles since accept, effects land when age hits LATENCY.
  int          age [3] = '{-1, -1, -1};
  logic [31:0] m_data [3];
  logic [31:0] mmem [3][4096];
  logic        l_store [3];
  logic [2:0]  l_op [3];
  logic [31:0] l_addr [3];
  logic [31:0] l_wdata [3];

  function automatic void apply_effect(input int k);
    logic [31:0] w, mask, v;
    int sh, idx;
    idx = int'(l_addr[k][13:2]);
    sh  = 8 * int'(l_addr[k][1:0]);
    w   = mmem[k][idx];
    if (l_store[k]) begin
      mask = (l_op[k] == 3'b000) ? 32'hFF : (l_op[k] == 3'b001) ? 32'hFFFF : 32'hFFFF_FFFF;
      mmem[k][idx] = (w & ~(mask << sh)) | ((l_wdata[k] & mask) << sh);
    end else begin
      case (l_op[k])
        3'b000: begin v = (w >> sh) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
        3'b001: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
        3'b100: v = (w >> sh) & 32'hFF;
        3'b101: v = (w >> sh) & 32'hFFFF;
        default: v = w;
      endcase
      m_data[k] = v;
    end
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_data[k] = '0;
      for (int i = 0; i < 4096; i++) mmem[k][i] = '0;
    end
  end

  always @(negedge clk) begin
    bit req_b, ok_b, e_stall, e_err;
    int nxt;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        age[k] = -1;
        m_data[k] = '0;
        check("reset_stall", k, 32'(stall[k]), 32'd0);
        check("reset_err", k, 32'(err[k]), 32'd0);
        check("reset_data", k, mdata[k], 32'd0);
      end else begin
        req_b = rd[k] | wr[k];
        ok_b  = aligned_fn(rd[k], wr[k], op[k], addr[k]);
        if (age[k] < 0) begin
          e_stall = req_b && ok_b;
          e_err   = req_b && !ok_b;
        end else begin
          e_stall = age[k] < lat_of(k);
          e_err   = 1'b0;
        end
        check("stall", k, 32'(stall[k]), 32'(e_stall));
        check("err", k, 32'(err[k]), 32'(e_err));
        check("data", k, mdata[k], m_data[k]);
        if (age[k] < 0) begin
          if (req_b && ok_b) begin
            l_store[k] = wr[k];
            l_op[k]    = op[k];
            l_addr[k]  = addr[k];
            l_wdata[k] = wdata[k];
            nxt = 1;
          end else nxt = -1;
        end else if (age[k] == lat_of(k)) nxt = -1;
        else nxt = age[k] + 1;
        if (nxt == lat_of(k)) apply_effect(k);
        age[k] = nxt;
      end
    end
  end

  task automatic present(input int k, input logic r, input logic w, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
    rd[k] = r; wr[k] = w; op[k] = o; addr[k] = a; wdata[k] = d;
  endtask

  task automatic idle(input int k, input int n);
    rd[k] = 1'b0; wr[k] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the request from accept through DONE; leaves it on the pins afterwards.
  task automatic access(input int k, input logic r, input logic w, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d, output int stalls, output int first);
    present(k, r, w, o, a, d);
    stalls = 0;
    first  = -1;
    for (int c = 0; c < lat_of(k) + 1; c++) begin
      #1;
      if (stall[k]) begin
        stalls++;
        if (first < 0) first = cyc;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_ops(input int k, input int n);
    logic [31:0] a;
    logic [2:0]  o;
    logic        r, w;
    int          kind, st, f;
    for (int i = 0; i < 16; i++) access(k, 1'b0, 1'b1, 3'b010, 32'h100 + 32'(4 * i), 32'd0, st, f);
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_C000) | 32'h100 | (32'($urandom_range(0, 15)) << 2);
      if (kind == 9) begin
        r = 1'($urandom_range(0, 1));
        w = ~r;
        o = $urandom_range(0, 1) ? 3'b010 : (r ? 3'b101 : 3'b001);
        a[0] = 1'b1;
        present(k, r, w, o, a, $urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        idle(k, 1);
      end else begin
        if (kind < 4) begin r = 1'b1; w = 1'b0; o = 3'($urandom_range(0, 7)); end
        else begin r = (kind == 8); w = 1'b1; o = 3'($urandom_range(0, 2)); end
        case (o)
          3'b001, 3'b101: a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
          3'b010:         a[1:0] = 2'b00;
          default:        a[1:0] = 2'($urandom_range(0, 3));
        endcase
        access(k, r, w, o, a, $urandom, st, f);
        idle(k, $urandom_range(0, 2));
      end
    end
    idle(k, 2);
  endtask

  initial begin
    int st, f_store, f_load;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; op[k] = 3'b000;
      addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++) begin
      check("idle_data", k, mdata[k], 32'd0);
      check("idle_stall", k, 32'(stall[k]), 32'd0);
      check("idle_err", k, 32'(err[k]), 32'd0);
    end

    // Word read latency on LATENCY=2
    access(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h8899_AABB, st, f_store); idle(1, 1);
    access(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st, f_load);
    check("lw_stall_cycles", 1, 32'(st), 32'd2);
    exp_q.push_back(32'h8899_AABB);
    check("lw_data", 1, mdata[1], exp_q.pop_front());
    idle(1, 3);
    check("lw_data_hold", 1, mdata[1], 32'h8899_AABB);

    // Byte lanes and extension
    access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0000_0000, st, f_store); idle(1, 1);
    access(1, 1'b0, 1'b1, 3'b000, 32'h23, 32'h0000_00F0, st, f_store); idle(1, 1);
    exp_q.push_back(32'hFFFF_FFF0);
    exp_q.push_back(32'h0000_00F0);
    exp_q.push_back(32'hF000_0000);
    access(1, 1'b1, 1'b0, 3'b000, 32'h23, 32'h0, st, f_load); idle(1, 1);
    check("lb_sext", 1, mdata[1], exp_q.pop_front());
    access(1, 1'b1, 1'b0, 3'b100, 32'h23, 32'h0, st, f_load); idle(1, 1);
    check("lbu_zext", 1, mdata[1], exp_q.pop_front());
    access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, st, f_load); idle(1, 1);
    check("lw_after_sb", 1, mdata[1], exp_q.pop_front());
    access(1, 1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_1234, st, f_store); idle(1, 1);
    access(1, 1'b1, 1'b0, 3'b101, 32'h22, 32'h0, st, f_load); idle(1, 1);
    check("lhu_zext", 1, mdata[1], 32'h0000_1234);

    // Misaligned halfword store held for three cycles
    present(1, 1'b0, 1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("misalign_err", 1, 32'(err[1]), 32'd1);
      check("misalign_stall", 1, 32'(stall[1]), 32'd0);
      @(posedge clk); #1;
    end
    idle(1, 1);
    access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, st, f_load); idle(1, 1);
    check("lw_after_misalign", 1, mdata[1], 32'h1234_0000);

    // Back-to-back with address wrap on LATENCY=1
    access(0, 1'b0, 1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, st, f_store);
    access(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, st, f_load);
    check("b2b_accept_gap", 0, 32'(f_load - f_store), 32'd2);
    check("wrap_data", 0, mdata[0], 32'hCAFE_F00D);
    idle(0, 1);

    // Reset during WAIT on LATENCY=4 discards the pending store
    access(2, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, st, f_store); idle(2, 1);
    present(2, 1'b0, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
    @(posedge clk); #3;
    rst_n[2] = 1'b0;
    #1;
    check("async_rst_stall", 2, 32'(stall[2]), 32'd0);
    rd[2] = 1'b0; wr[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    idle(2, 2);
    access(2, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, st, f_load); idle(2, 1);
    check("rst_discard_store", 2, mdata[2], 32'h0);

    for (int k = 0; k < 3; k++) rand_ops(k, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
